uart_wb_sequencer: RTL and testbench

- Wishbone master that configures the uart_top 16550 core after reset, then shares its register port between a byte-transmit requester and a receive-drain path.
- Sits between testbench/host-side byte streams and the uart_top Wishbone slave, in place of wishbone_driver.
- Programs the divisor, line control, FIFO and interrupt registers.
- Then polls LSR and moves bytes to THR or from RBR, with round-robin arbitration and an ack timeout.

---
 rtl/uart_wb_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_wb_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_sequencer.sv
// Wishbone master that programs a 16550-style UART after reset, then arbitrates the register
// port between a byte-transmit requester and a receive-drain path.
module uart_wb_sequencer #(
    parameter logic [15:0] DIVISOR     = 16'h001B,
    parameter logic [7:0]  LCR_VAL     = 8'h03,
    parameter logic [7:0]  FCR_VAL     = 8'h07,
    parameter logic [7:0]  IER_VAL     = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned ADDR_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    output logic                  cfg_done,
    output logic                  bus_err,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    input  logic                  rx_en,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [3:0]            wb_sel_o,
    input  logic                  wb_ack_i
);

    typedef enum logic [3:0] {
        StCfg0, StCfg1, StCfg2, StCfg3, StCfg4, StCfg5,
        StReady, StPoll, StTxw, StRxr, StError
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AdrData = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] AdrIer  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AdrFcr  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AdrLcr  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] AdrLsr  = ADDR_WIDTH'(5);
    localparam logic [7:0]            TimerLast = 8'(ACK_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic                    acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [7:0]              dat_q, dat_d;
    logic                    we_q, we_d;
    logic [7:0]              timer_q, timer_d;
    logic                    bus_err_q, bus_err_d;
    logic                    pend_q, pend_d;
    logic                    rr_q, rr_d;
    logic                    both_q, both_d;
    logic                    tx_ready_q, tx_ready_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [7:0]              rx_data_q, rx_data_d;

    logic                    is_op, done, expired;
    logic                    t_elig, r_elig;
    logic [ADDR_WIDTH-1:0]   l_adr;
    logic [7:0]              l_dat;
    logic                    l_we;
    state_e                  idle_next;

    logic unused_dat_hi;
    assign unused_dat_hi = ^wb_dat_i[31:8];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        timer_d    = timer_q;
        bus_err_d  = bus_err_q;
        pend_d     = pend_q | cfg_start;
        rr_d       = rr_q;
        both_d     = both_q;
        tx_ready_d = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        l_adr      = AdrData;
        l_dat      = 8'h00;
        l_we       = 1'b0;
        t_elig     = 1'b0;
        r_elig     = 1'b0;

        is_op     = (state_q != StReady) && (state_q != StError);
        done      = acc_q && wb_ack_i;
        expired   = acc_q && !wb_ack_i && (timer_q == TimerLast);
        // A latched cfg_start diverts the return to READY straight into a new configuration.
        idle_next = pend_d ? StCfg0 : StReady;

        unique case (state_q)
            StCfg0: begin
                l_adr = AdrLcr; l_dat = 8'h80 | LCR_VAL; l_we = 1'b1;
                if (done) state_d = StCfg1;
            end
            StCfg1: begin
                l_adr = AdrData; l_dat = DIVISOR[7:0]; l_we = 1'b1;
                if (done) state_d = StCfg2;
            end
            StCfg2: begin
                l_adr = AdrIer; l_dat = DIVISOR[15:8]; l_we = 1'b1;
                if (done) state_d = StCfg3;
            end
            StCfg3: begin
                l_adr = AdrLcr; l_dat = LCR_VAL; l_we = 1'b1;
                if (done) state_d = StCfg4;
            end
            StCfg4: begin
                l_adr = AdrFcr; l_dat = FCR_VAL; l_we = 1'b1;
                if (done) state_d = StCfg5;
            end
            StCfg5: begin
                l_adr = AdrIer; l_dat = IER_VAL; l_we = 1'b1;
                if (done) state_d = idle_next;
            end
            StReady: begin
                if (pend_d) begin
                    state_d   = StCfg0;
                    bus_err_d = 1'b0;
                end else if (tx_valid || rx_en) begin
                    state_d = StPoll;
                end
            end
            StPoll: begin
                l_adr = AdrLsr;
                if (done) begin
                    t_elig = wb_dat_i[5] & tx_valid;
                    r_elig = wb_dat_i[0] & rx_en;
                    both_d = t_elig & r_elig;
                    if (t_elig && (!r_elig || !rr_q)) state_d = StTxw;
                    else if (r_elig)                  state_d = StRxr;
                    else                              state_d = idle_next;
                end
            end
            StTxw: begin
                l_adr = AdrData; l_dat = tx_data; l_we = 1'b1;
                if (done) begin
                    tx_ready_d = 1'b1;
                    if (both_q) rr_d = ~rr_q;
                    state_d = idle_next;
                end
            end
            StRxr: begin
                l_adr = AdrData;
                if (done) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = wb_dat_i[7:0];
                    if (both_q) rr_d = ~rr_q;
                    state_d = idle_next;
                end
            end
            StError: begin
                if (cfg_start) begin
                    state_d   = StCfg0;
                    bus_err_d = 1'b0;
                end
            end
            default: state_d = StCfg0;
        endcase

        // Shared bus engine: launch on the first cycle of an access state, hold until ack/timeout.
        if (is_op) begin
            if (!acc_q) begin
                acc_d   = 1'b1;
                adr_d   = l_adr;
                dat_d   = l_dat;
                we_d    = l_we;
                timer_d = 8'h00;
            end else if (done) begin
                acc_d = 1'b0;
            end else if (expired) begin
                acc_d     = 1'b0;
                bus_err_d = 1'b1;
                state_d   = StError;
            end else begin
                timer_d = timer_q + 8'h01;
            end
        end

        if (state_d == StCfg0 && state_q != StCfg0) pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StCfg0;
            acc_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= 8'h00;
            we_q       <= 1'b0;
            timer_q    <= 8'h00;
            bus_err_q  <= 1'b0;
            pend_q     <= 1'b0;
            rr_q       <= 1'b0;
            both_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            timer_q    <= timer_d;
            bus_err_q  <= bus_err_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            both_q     <= both_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign cfg_done = (state_q == StReady);
    assign bus_err  = bus_err_q;
    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = {24'h000000, dat_q};
    assign wb_we_o  = we_q;
    assign wb_cyc_o = acc_q;
    assign wb_stb_o = acc_q;
    assign wb_sel_o = acc_q ? 4'b0001 : 4'b0000;

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Scoreboard bench for uart_wb_sequencer: a behavioural Wishbone slave answers the DUT, and a
// monitor matches every write, RBR read, tx_ready and rx_valid against an expected-event queue.
module tb_uart_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_done, bus_err;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        rx_en = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    uart_wb_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_done(cfg_done),
        .bus_err(bus_err), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i)
    );

    // kind: 0 = register write, 1 = RBR read, 2 = tx_ready pulse, 3 = rx_valid pulse
    typedef struct {
        int         kind;
        logic [4:0] adr;
        logic [7:0] dat;
    } ev_t;

    ev_t        sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         poll_cnt = 0;
    logic [7:0] lsr_val = 8'h00;
    logic [7:0] rbr_val = 8'hA5;
    int         ack_lat = 0;
    bit         block_adr1 = 1'b0;
    int         wait_cnt = 0;
    bit         prev_ack = 1'b0;

    function automatic void push(int kind, logic [4:0] adr, logic [7:0] dat);
        ev_t e;
        e.kind = kind; e.adr = adr; e.dat = dat;
        sb.push_back(e);
    endfunction

    function automatic void push_cfg();
        push(0, 5'd3, 8'h83);
        push(0, 5'd0, 8'h1B);
        push(0, 5'd1, 8'h00);
        push(0, 5'd3, 8'h03);
        push(0, 5'd2, 8'h07);
        push(0, 5'd1, 8'h00);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void sb_event(int kind, logic [4:0] adr, logic [7:0] dat);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d adr %0h dat %0h, expected none at %0t",
                     kind, adr, dat, $time);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || ((kind == 0 || kind == 1) && e.adr != adr) ||
            ((kind == 0 || kind == 3) && e.dat != dat)) begin
            n_fail++;
            $display("FAIL sb_event: got kind %0d adr %0h dat %0h, expected kind %0d adr %0h dat %0h at %0t",
                     kind, adr, dat, e.kind, e.adr, e.dat, $time);
        end
    endfunction

    // Wishbone slave: ack after ack_lat wait cycles; LSR/RBR reads return bench-held values.
    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (!(block_adr1 && wb_we_o && wb_adr_o == 5'd1)) begin
                if (wait_cnt >= ack_lat) begin
                    wb_ack_i <= 1'b1;
                    wait_cnt <= 0;
                    if (!wb_we_o)
                        wb_dat_i <= {24'h0, (wb_adr_o == 5'd5) ? lsr_val : rbr_val};
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end else begin
            wb_ack_i <= 1'b0;
            wait_cnt <= 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ack) begin
                n_checks++;
                if (wb_stb_o) begin
                    n_fail++;
                    $display("FAIL idle_gap: got stb 1 expected 0 after ack at %0t", $time);
                end
            end
            if (tx_ready) sb_event(2, 5'd0, 8'h00);
            if (rx_valid) sb_event(3, 5'd0, rx_data);
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                n_checks++;
                if (wb_sel_o !== 4'b0001 || wb_dat_o[31:8] !== 24'h0) begin
                    n_fail++;
                    $display("FAIL sel_dat_hi: got sel %0h dat %0h expected sel 1 upper 0",
                             wb_sel_o, wb_dat_o);
                end
                if (!wb_we_o && wb_adr_o == 5'd5) poll_cnt++;
                else sb_event(wb_we_o ? 0 : 1, wb_adr_o, wb_dat_o[7:0]);
            end
            prev_ack = wb_cyc_o && wb_stb_o && wb_ack_i;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic wait_idle(string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !wb_cyc_o && cfg_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic pulse_cfg_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        int p0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        chk("rst_adr_we_sel", {23'h0, wb_adr_o, wb_we_o, wb_sel_o}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_status", {28'h0, cfg_done, bus_err, tx_ready, rx_valid}, 32'h0);
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);

        // Configuration after reset release
        push_cfg();
        rst_n = 1'b1;
        wait_idle("cfg_after_reset");
        chk("cfg_done", {31'h0, cfg_done}, 32'h1);

        // Single transmit with THRE set
        push(0, 5'd0, 8'h5A);
        push(2, 5'd0, 8'h00);
        tx_data = 8'h5A; lsr_val = 8'h60; tx_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready) begin seen = 1'b1; break; end
        end
        tx_valid = 1'b0;
        chk("tx_ready_seen", {31'h0, seen}, 32'h1);
        wait_idle("tx_single");

        // THRE clear: polls repeat, no THR write
        lsr_val = 8'h00; p0 = poll_cnt; tx_valid = 1'b1;
        repeat (100) @(negedge clk);
        tx_valid = 1'b0;
        wait_idle("poll_no_write");
        chk("poll_repeat", {31'h0, (poll_cnt - p0) >= 5}, 32'h1);

        // Both eligible: round-robin TX, RX, TX, RX
        tx_data = 8'h3C; rbr_val = 8'hA5; lsr_val = 8'h61;
        for (int k = 0; k < 2; k++) begin
            push(0, 5'd0, 8'h3C); push(2, 5'd0, 8'h00);
            push(1, 5'd0, 8'h00); push(3, 5'd0, 8'hA5);
        end
        rx_en = 1'b1; tx_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 400 && n < 2; i++) begin
            @(negedge clk);
            if (rx_valid) n++;
        end
        tx_valid = 1'b0; rx_en = 1'b0;
        chk("rr_rx_count", n, 2);
        wait_idle("round_robin");
        chk("rx_data_hold", {24'h0, rx_data}, 32'hA5);

        // Ack withheld on CFG2 -> timeout, ERROR
        block_adr1 = 1'b1;
        push(0, 5'd3, 8'h83); push(0, 5'd0, 8'h1B);
        pulse_cfg_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wb_stb_o && wb_adr_o == 5'd1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("cfg2_reached", {31'h0, seen}, 32'h1);
        n = 0;
        while (wb_stb_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_len", n, 64);
        chk("timeout_bus_err", {31'h0, bus_err}, 32'h1);
        chk("timeout_cfg_done", {31'h0, cfg_done}, 32'h0);
        repeat (10) @(negedge clk);
        chk("error_stays_idle", {30'h0, wb_cyc_o, bus_err}, 32'h1);
        chk("error_sb_drained", sb.size(), 0);
        block_adr1 = 1'b0;
        push_cfg();
        pulse_cfg_start();
        chk("cfg_start_clears_err", {31'h0, bus_err}, 32'h0);
        wait_idle("cfg_after_error");

        // cfg_start during THR write: write completes, then full configuration
        ack_lat = 3; lsr_val = 8'h20; tx_data = 8'h77;
        push(0, 5'd0, 8'h77); push(2, 5'd0, 8'h00);
        push_cfg();
        tx_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_stb_o && wb_we_o && wb_adr_o == 5'd0) begin seen = 1'b1; break; end
        end
        chk("thr_write_seen", {31'h0, seen}, 32'h1);
        tx_valid = 1'b0;
        pulse_cfg_start();
        wait_idle("cfg_start_mid_txw");

        // Reset asserted mid-RXR
        ack_lat = 6; lsr_val = 8'h01; rx_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_stb_o && !wb_we_o && wb_adr_o == 5'd0) begin seen = 1'b1; break; end
        end
        chk("rbr_read_seen", {31'h0, seen}, 32'h1);
        rx_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        chk("async_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        repeat (2) @(negedge clk);
        ack_lat = 0;
        push_cfg();
        rst_n = 1'b1;
        wait_idle("cfg_after_mid_reset");
        chk("rx_data_after_reset", {24'h0, rx_data}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
